// File: rtl/bitmask_frame_packer.sv
// Packs a 1-bit-per-pixel camera stream into 16-bit words and writes them to ping-pong SPRAM banks.
// Latency: a word is written 1 cycle after its last pixel (or after the pixel that moves to a new word).
// No backpressure: one pixel per cycle is always accepted. A busy reader pins the bank.
// Optional: define BITMASK_POPCOUNT_EN to add the ones_count output.
module bitmask_frame_packer #(
  parameter int BANK_WORDS = 4800,
  parameter int ADDR_W     = 14
) (
  input  logic              cam_pclk,
  input  logic              nreset,
  input  logic [16:0]       pix_addr,
  input  logic              pix_data,
  input  logic              pix_en,
  input  logic              in_frame,
  input  logic              frame_done,
  input  logic              rd_busy,
  output logic [ADDR_W-1:0] spram_addr,
  output logic [15:0]       spram_wdata,
  output logic              spram_we,
  output logic              frame_ready,
  output logic              ready_bank,
  output logic              active_bank,
  output logic              overflow_err
`ifdef BITMASK_POPCOUNT_EN
  ,
  output logic [16:0]       ones_count
`endif
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  localparam logic [12:0]       BANK_WORDS_W = 13'(BANK_WORDS);
  localparam logic [ADDR_W-1:0] BANK1_BASE   = ADDR_W'(BANK_WORDS);

  state_t              state_q, state_d;
  logic [15:0]         buf_q, buf_d;
  logic                word_open_q, word_open_d;
  logic [12:0]         cur_idx_q, cur_idx_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   spram_addr_q, spram_addr_d;
  logic [15:0]         spram_wdata_q, spram_wdata_d;
  logic                spram_we_q, spram_we_d;
  logic                frame_ready_q, frame_ready_d;
  logic                ready_bank_q, ready_bank_d;
  logic                active_bank_q, active_bank_d;
  logic                in_frame_dly_q;
  logic                rd_busy_meta_q, rd_busy_s;
`ifdef BITMASK_POPCOUNT_EN
  logic [16:0]         ones_cnt_q, ones_cnt_d;
  logic [16:0]         ones_count_q, ones_count_d;
`endif

  logic [12:0]         word_idx;
  logic [3:0]          bit_pos;
  logic                frame_start;
  logic [ADDR_W-1:0]   bank_base;
  logic [15:0]         pix_word;
  logic                flush_old;

  assign word_idx    = pix_addr[16:4];
  assign bit_pos     = pix_addr[3:0];
  assign frame_start = in_frame && !in_frame_dly_q;
  assign bank_base   = active_bank_q ? BANK1_BASE : '0;

  // Two-flop synchronizer for the reader busy flag from the system clock domain.
  always_ff @(posedge cam_pclk or negedge nreset) begin
    if (!nreset) begin
      rd_busy_meta_q <= 1'b0;
      rd_busy_s      <= 1'b0;
    end else begin
      rd_busy_meta_q <= rd_busy;
      rd_busy_s      <= rd_busy_meta_q;
    end
  end

  // State, word buffer and registered SPRAM/status outputs.
  always_ff @(posedge cam_pclk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      word_open_q    <= 1'b0;
      cur_idx_q      <= '0;
      overflow_q     <= 1'b0;
      spram_addr_q   <= '0;
      spram_wdata_q  <= '0;
      spram_we_q     <= 1'b0;
      frame_ready_q  <= 1'b0;
      ready_bank_q   <= 1'b1;
      active_bank_q  <= 1'b0;
      in_frame_dly_q <= 1'b0;
`ifdef BITMASK_POPCOUNT_EN
      ones_cnt_q     <= '0;
      ones_count_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      word_open_q    <= word_open_d;
      cur_idx_q      <= cur_idx_d;
      overflow_q     <= overflow_d;
      spram_addr_q   <= spram_addr_d;
      spram_wdata_q  <= spram_wdata_d;
      spram_we_q     <= spram_we_d;
      frame_ready_q  <= frame_ready_d;
      ready_bank_q   <= ready_bank_d;
      active_bank_q  <= active_bank_d;
      in_frame_dly_q <= in_frame;
`ifdef BITMASK_POPCOUNT_EN
      ones_cnt_q     <= ones_cnt_d;
      ones_count_q   <= ones_count_d;
`endif
    end
  end

  // Next-state logic: pixel packing, word flushes, frame hand-off and bank switching.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    word_open_d   = word_open_q;
    cur_idx_d     = cur_idx_q;
    overflow_d    = overflow_q;
    spram_addr_d  = spram_addr_q;
    spram_wdata_d = spram_wdata_q;
    spram_we_d    = 1'b0;
    frame_ready_d = 1'b0;
    ready_bank_d  = ready_bank_q;
    active_bank_d = active_bank_q;
    pix_word      = buf_q;
    flush_old     = 1'b0;
`ifdef BITMASK_POPCOUNT_EN
    ones_cnt_d    = ones_cnt_q;
    ones_count_d  = ones_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d     = CAPTURE;
          buf_d       = '0;
          word_open_d = 1'b0;
          overflow_d  = 1'b0;
`ifdef BITMASK_POPCOUNT_EN
          ones_cnt_d  = '0;
`endif
        end
      end

      CAPTURE: begin
        if (frame_start) begin
          // Restarted frame: drop the partial word, keep the bank.
          buf_d       = '0;
          word_open_d = 1'b0;
          overflow_d  = 1'b0;
`ifdef BITMASK_POPCOUNT_EN
          ones_cnt_d  = '0;
`endif
        end else if (!in_frame && !frame_done) begin
          // Frame aborted upstream: nothing is announced.
          state_d     = IDLE;
          buf_d       = '0;
          word_open_d = 1'b0;
        end else begin
          if (pix_en) begin
            if (word_idx >= BANK_WORDS_W) begin
              overflow_d = 1'b1;
            end else begin
`ifdef BITMASK_POPCOUNT_EN
              ones_cnt_d = ones_cnt_q + 17'(pix_data);
`endif
              if (word_open_q && (word_idx != cur_idx_q)) begin
                // Jump to another word: write out the old one, start the new one empty.
                flush_old     = 1'b1;
                spram_we_d    = 1'b1;
                spram_addr_d  = bank_base + ADDR_W'(cur_idx_q);
                spram_wdata_d = buf_q;
                pix_word      = '0;
              end
              pix_word[bit_pos] = pix_data;
              cur_idx_d         = word_idx;
              if ((bit_pos == 4'd15) && !flush_old) begin
                spram_we_d    = 1'b1;
                spram_addr_d  = bank_base + ADDR_W'(word_idx);
                spram_wdata_d = pix_word;
                buf_d         = '0;
                word_open_d   = 1'b0;
              end else begin
                // A bit-15 pixel that also forced a flush stays open until the next write slot.
                buf_d       = pix_word;
                word_open_d = 1'b1;
              end
            end
          end
          if (frame_done) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (word_open_q) begin
          spram_we_d    = 1'b1;
          spram_addr_d  = bank_base + ADDR_W'(cur_idx_q);
          spram_wdata_d = buf_q;
        end
        buf_d         = '0;
        word_open_d   = 1'b0;
        frame_ready_d = 1'b1;
        ready_bank_d  = active_bank_q;
        // A busy reader keeps its bank; the next frame overwrites the one just filled.
        if (!rd_busy_s) begin
          active_bank_d = !active_bank_q;
        end
`ifdef BITMASK_POPCOUNT_EN
        ones_count_d  = ones_cnt_q;
`endif
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spram_addr   = spram_addr_q;
  assign spram_wdata  = spram_wdata_q;
  assign spram_we     = spram_we_q;
  assign frame_ready  = frame_ready_q;
  assign ready_bank   = ready_bank_q;
  assign active_bank  = active_bank_q;
  assign overflow_err = overflow_q;
`ifdef BITMASK_POPCOUNT_EN
  assign ones_count   = ones_count_q;
`endif

endmodule

// File: tb/tb_bitmask_frame_packer.sv
// Scoreboard bench for bitmask_frame_packer: directed frames, expected SPRAM writes and
// frame_ready events are queued at stimulus time and popped by an independent output monitor.
// Popcount checks are present only when BITMASK_POPCOUNT_EN is defined.
module tb_bitmask_frame_packer;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        cam_pclk   = 1'b0;
  logic        nreset     = 1'b0;
  logic [16:0] pix_addr   = '0;
  logic        pix_data   = 1'b0;
  logic        pix_en     = 1'b0;
  logic        in_frame   = 1'b0;
  logic        frame_done = 1'b0;
  logic        rd_busy    = 1'b0;
  logic [13:0] spram_addr;
  logic [15:0] spram_wdata;
  logic        spram_we;
  logic        frame_ready;
  logic        ready_bank;
  logic        active_bank;
  logic        overflow_err;
`ifdef BITMASK_POPCOUNT_EN
  logic [16:0] ones_count;
`endif

  wr_t        exp_wr[$];
  logic [1:0] exp_fr[$];
  int n_vec     = 0;
  int n_miss    = 0;
  int wr_seen   = 0;
  int wr_pushed = 0;

  bitmask_frame_packer #(.BANK_WORDS(4800), .ADDR_W(14)) dut (
    .cam_pclk    (cam_pclk),
    .nreset      (nreset),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .pix_en      (pix_en),
    .in_frame    (in_frame),
    .frame_done  (frame_done),
    .rd_busy     (rd_busy),
    .spram_addr  (spram_addr),
    .spram_wdata (spram_wdata),
    .spram_we    (spram_we),
    .frame_ready (frame_ready),
    .ready_bank  (ready_bank),
    .active_bank (active_bank),
    .overflow_err(overflow_err)
`ifdef BITMASK_POPCOUNT_EN
    ,
    .ones_count  (ones_count)
`endif
  );

  always #5 cam_pclk = ~cam_pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Output monitor: every write and every frame_ready must match the head of its queue.
  always @(negedge cam_pclk) begin
    wr_t        e;
    logic [1:0] f;
    if (spram_we === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: actual addr %0d data %h required no write", spram_addr, spram_wdata);
      end else begin
        e = exp_wr.pop_front();
        check("write_addr_data", 32'({spram_addr, spram_wdata}), 32'(e));
      end
    end
    if (frame_ready === 1'b1) begin
      if (exp_fr.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_frame_ready: actual ready_bank %0d active_bank %0d required none", ready_bank, active_bank);
      end else begin
        f = exp_fr.pop_front();
        check("frame_ready_{ready,active}", 32'({ready_bank, active_bank}), 32'(f));
      end
    end
  end

  task automatic cyc();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic push_wr(input int a, input logic [15:0] d);
    exp_wr.push_back({14'(a), d});
    wr_pushed++;
  endtask

  task automatic push_fr(input logic rb, input logic ab);
    exp_fr.push_back({rb, ab});
  endtask

  task automatic pix(input int a, input logic d, input logic done);
    pix_addr   = 17'(a);
    pix_data   = d;
    pix_en     = 1'b1;
    frame_done = done;
    cyc();
    pix_en     = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic start_frame();
    in_frame = 1'b1;
    cyc();
  endtask

  task automatic end_frame();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    in_frame   = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_spram_addr"},   32'(spram_addr),   32'd0);
    check({tag, "_spram_wdata"},  32'(spram_wdata),  32'd0);
    check({tag, "_spram_we"},     32'(spram_we),     32'd0);
    check({tag, "_frame_ready"},  32'(frame_ready),  32'd0);
    check({tag, "_ready_bank"},   32'(ready_bank),   32'd1);
    check({tag, "_active_bank"},  32'(active_bank),  32'd0);
    check({tag, "_overflow_err"}, 32'(overflow_err), 32'd0);
`ifdef BITMASK_POPCOUNT_EN
    check({tag, "_ones_count"},   32'(ones_count),   32'd0);
`endif
  endtask

  // Watchdog: the directed sequence is fixed-length, so this only fires on a hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;

    // Power-on reset.
    cyc();
    cyc();
    check_reset("reset");
    nreset = 1'b1;
    cyc();

    // Full word 0xA5C3 into bank 0, then an empty end-of-frame hand-off.
    pat = 16'hA5C3;
    push_wr(0, 16'hA5C3);
    push_fr(1'b0, 1'b1);
    start_frame();
    for (int n = 0; n < 16; n++) pix(n, pat[n], 1'b0);
    end_frame();
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_a5c3", 32'(ones_count), 32'd8);
`endif

    // Partial word flushed from bank 1: pixels 16..20 set.
    push_wr(4801, 16'h001F);
    push_fr(1'b1, 1'b0);
    start_frame();
    for (int n = 16; n <= 20; n++) pix(n, 1'b1, 1'b0);
    end_frame();
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_partial", 32'(ones_count), 32'd5);
`endif

    // Word skip, overflow drop, and frame_done coincident with a pixel (bank 0).
    push_wr(0, 16'h0020);
    push_wr(2, 16'h0003);
    push_fr(1'b0, 1'b1);
    start_frame();
    pix(5, 1'b1, 1'b0);
    pix(32, 1'b1, 1'b0);
    pix(76800, 1'b1, 1'b0);
    check("overflow_set", 32'(overflow_err), 32'd1);
    pix(33, 1'b1, 1'b1);
    in_frame = 1'b0;
    cyc();
    cyc();
    check("overflow_sticky", 32'(overflow_err), 32'd1);
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_overflow_excluded", 32'(ones_count), 32'd3);
`endif

    // Abort after 8 pixels and re-rise: no write, no frame_ready, overflow cleared.
    start_frame();
    check("overflow_cleared", 32'(overflow_err), 32'd0);
    for (int n = 0; n < 8; n++) pix(n, 1'b1, 1'b0);
    in_frame = 1'b0;
    cyc();
    start_frame();
    for (int n = 0; n < 8; n++) pix(n, 1'b1, 1'b0);
    in_frame = 1'b0;
    cyc();
    cyc();
    check("abort_bank_kept", 32'(active_bank), 32'd1);
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_held", 32'(ones_count), 32'd3);
`endif

    // Reset asserted in the middle of a word.
    start_frame();
    for (int n = 0; n < 4; n++) pix(n, 1'b1, 1'b0);
    #2;
    nreset   = 1'b0;
    in_frame = 1'b0;
    #1;
    check_reset("midreset");
    cyc();
    nreset = 1'b1;
    cyc();

    // Reader busy at frame end: bank 0 is announced but stays active.
    rd_busy = 1'b1;
    cyc();
    cyc();
    cyc();
    pat = 16'h1234;
    push_wr(0, 16'h1234);
    push_fr(1'b0, 1'b0);
    start_frame();
    for (int n = 0; n < 16; n++) pix(n, pat[n], 1'b0);
    end_frame();
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_busy", 32'(ones_count), 32'd5);
`endif
    rd_busy = 1'b0;
    cyc();
    cyc();
    cyc();

    // Full 320x240 frame into bank 0 again: word w < 1000 has only bit (w % 16) set.
    for (int w = 0; w < 4800; w++) begin
      push_wr(w, (w < 1000) ? (16'h0001 << (w % 16)) : 16'h0000);
    end
    push_fr(1'b0, 1'b1);
    start_frame();
    for (int p = 0; p < 76800; p++) begin
      pix(p, ((p >> 4) < 1000) && ((p % 16) == ((p >> 4) % 16)), 1'b0);
    end
    end_frame();
    check("full_frame_active_bank", 32'(active_bank), 32'd1);
`ifdef BITMASK_POPCOUNT_EN
    check("popcount_full_frame", 32'(ones_count), 32'd1000);
`endif

    cyc();
    cyc();
    check("write_total", 32'(wr_seen), 32'(wr_pushed));
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("frame_ready_outstanding", 32'(exp_fr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
